// File: rtl/scope_capture.sv
// Oscilloscope capture stage: channel select, decimation, level/slope trigger
// and a DEPTH-sample capture buffer with a registered read-before-write port.
module scope_capture #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] sin_in,
  input  logic [DW-1:0] cos_in,
  input  logic [DW-1:0] squ_in,
  input  logic [DW-1:0] saw_in,
  input  logic [1:0]    sel,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_slope,
  input  logic [7:0]    decim,
  input  logic          arm,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CAPT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] rd_data_q;

  logic [1:0]    sel_q, sel_d;
  logic [DW-1:0] level_q, level_d;
  logic          slope_q, slope_d;
  logic [7:0]    decim_q, decim_d;
  logic [7:0]    dcnt_q, dcnt_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [DW-1:0] prev_q, prev_d;
  logic          pvalid_q, pvalid_d;

  logic [DW-1:0] mem_q [DEPTH];

  logic          active_s;
  logic          arm_ok_s;
  logic          strobe_s;
  logic          trig_hit_s;
  logic          last_s;
  logic [DW-1:0] cur_s;
  logic          we_s;
  logic [AW-1:0] waddr_s;
  logic [DW-1:0] wdata_s;

  assign active_s = (state_q == S_WAIT) || (state_q == S_CAPT);
  assign arm_ok_s = arm && !abort && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign strobe_s = active_s && (dcnt_q == decim_q);
  assign last_s   = (wptr_q == LAST_ADDR);

  // Channel mux driven by the configuration latched at arm time
  always_comb begin
    cur_s = sin_in;
    case (sel_q)
      2'd0:    cur_s = sin_in;
      2'd1:    cur_s = cos_in;
      2'd2:    cur_s = squ_in;
      2'd3:    cur_s = saw_in;
      default: cur_s = sin_in;
    endcase
  end

  // Trigger condition; a crossing needs a valid previous strobe sample
  always_comb begin
    trig_hit_s = 1'b0;
    if (!pvalid_q) begin
      trig_hit_s = 1'b0;
    end else if (slope_q) begin
      trig_hit_s = (prev_q < level_q) && (cur_s >= level_q);
    end else begin
      trig_hit_s = (prev_q > level_q) && (cur_s <= level_q);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; abort wins over everything else
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) state_d = S_WAIT;
          else     state_d = S_IDLE;
        end
        S_WAIT: begin
          if (strobe_s && trig_hit_s) state_d = S_CAPT;
          else                        state_d = S_WAIT;
        end
        S_CAPT: begin
          if (strobe_s && last_s) state_d = S_DONE;
          else                    state_d = S_CAPT;
        end
        S_DONE: begin
          if (arm) state_d = S_WAIT;
          else     state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs, computed from the next state so the registers track it
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      S_IDLE:  begin busy_d = 1'b0; done_d = 1'b0; end
      S_WAIT:  begin busy_d = 1'b1; done_d = 1'b0; end
      S_CAPT:  begin busy_d = 1'b1; done_d = 1'b0; end
      S_DONE:  begin busy_d = 1'b0; done_d = 1'b1; end
      default: begin busy_d = 1'b0; done_d = 1'b0; end
    endcase
  end

  // Config latch, decimation counter, trigger history and write pointer
  always_comb begin
    sel_d    = sel_q;
    level_d  = level_q;
    slope_d  = slope_q;
    decim_d  = decim_q;
    dcnt_d   = dcnt_q;
    wptr_d   = wptr_q;
    prev_d   = prev_q;
    pvalid_d = pvalid_q;
    we_s     = 1'b0;
    waddr_s  = wptr_q;
    wdata_s  = cur_s;
    if (abort) begin
      dcnt_d = 8'd0;
    end else if (arm_ok_s) begin
      sel_d    = sel;
      level_d  = trig_level;
      slope_d  = trig_slope;
      decim_d  = decim;
      dcnt_d   = 8'd0;
      wptr_d   = {AW{1'b0}};
      pvalid_d = 1'b0;
    end else if (active_s) begin
      if (strobe_s) begin
        dcnt_d = 8'd0;
        if (state_q == S_WAIT) begin
          prev_d   = cur_s;
          pvalid_d = 1'b1;
          if (trig_hit_s) begin
            we_s    = 1'b1;
            waddr_s = {AW{1'b0}};
            wptr_d  = {{(AW-1){1'b0}}, 1'b1};
          end else begin
            we_s = 1'b0;
          end
        end else begin
          we_s    = 1'b1;
          waddr_s = wptr_q;
          // The final write leaves the pointer parked at the last address
          if (!last_s) wptr_d = wptr_q + {{(AW-1){1'b0}}, 1'b1};
          else         wptr_d = wptr_q;
        end
      end else begin
        dcnt_d = dcnt_q + 8'd1;
      end
    end else begin
      dcnt_d = 8'd0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q    <= 2'd0;
      level_q  <= {DW{1'b0}};
      slope_q  <= 1'b0;
      decim_q  <= 8'd0;
      dcnt_q   <= 8'd0;
      wptr_q   <= {AW{1'b0}};
      prev_q   <= {DW{1'b0}};
      pvalid_q <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      level_q  <= level_d;
      slope_q  <= slope_d;
      decim_q  <= decim_d;
      dcnt_q   <= dcnt_d;
      wptr_q   <= wptr_d;
      prev_q   <= prev_d;
      pvalid_q <= pvalid_d;
    end
  end

  // Registered status outputs and readback word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= {DW{1'b0}};
    end else begin
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_data_q <= mem_q[rd_addr];
    end
  end

  // Capture buffer write port; deliberately not reset
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_q[waddr_s] <= wdata_s;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_scope_capture.sv
// Directed bench for scope_capture: a table of capture scenarios plus
// hand-written sequences for reset, abort, stuck trigger and busy-arm cases.
module tb_scope_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] sin_in, cos_in, squ_in, saw_in;
  logic [1:0]  sel;
  logic [11:0] trig_level;
  logic        trig_slope;
  logic [7:0]  decim;
  logic        arm, abort;
  logic        busy, done;
  logic [7:0]  rd_addr;
  logic [11:0] rd_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]  ch;
  logic [11:0] ramp_val;
  logic [11:0] bg_val;
  logic        ramp_on;
  logic        ramp_down;

  typedef struct {
    logic [1:0]  sel;
    logic [11:0] level;
    logic        slope;
    logic [7:0]  decim;
    logic [11:0] start;
    logic        down;
    int          arm_pulse;
    int          done_edge;
    int          mem0;
    int          stride;
  } vec_t;

  vec_t vecs [5];
  int   rd_addrs [5];

  scope_capture #(.DEPTH(256), .AW(8), .DW(12)) dut (
    .clk(clk), .reset(reset),
    .sin_in(sin_in), .cos_in(cos_in), .squ_in(squ_in), .saw_in(saw_in),
    .sel(sel), .trig_level(trig_level), .trig_slope(trig_slope), .decim(decim),
    .arm(arm), .abort(abort), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply();
    sin_in = (ch == 2'd0) ? ramp_val : bg_val;
    cos_in = (ch == 2'd1) ? ramp_val : bg_val;
    squ_in = (ch == 2'd2) ? ramp_val : bg_val;
    saw_in = (ch == 2'd3) ? ramp_val : bg_val;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (ramp_on) ramp_val = ramp_down ? ramp_val - 12'd1 : ramp_val + 12'd1;
    apply();
  endtask

  initial begin
    int   done_at;
    int   cnt;
    vec_t v;
    logic [11:0] e;

    vecs[0] = '{sel:2'd3, level:12'd100,  slope:1'b1, decim:8'd0, start:12'd0,    down:1'b0,
                arm_pulse:0, done_edge:355,  mem0:100,  stride:1};
    vecs[1] = '{sel:2'd3, level:12'd100,  slope:1'b1, decim:8'd3, start:12'd0,    down:1'b0,
                arm_pulse:2, done_edge:1120, mem0:100,  stride:4};
    vecs[2] = '{sel:2'd0, level:12'd2048, slope:1'b0, decim:8'd0, start:12'd4095, down:1'b1,
                arm_pulse:0, done_edge:2302, mem0:2048, stride:-1};
    vecs[3] = '{sel:2'd1, level:12'd100,  slope:1'b1, decim:8'd1, start:12'd0,    down:1'b0,
                arm_pulse:0, done_edge:610,  mem0:100,  stride:2};
    vecs[4] = '{sel:2'd2, level:12'd500,  slope:1'b0, decim:8'd0, start:12'd1000, down:1'b1,
                arm_pulse:0, done_edge:755,  mem0:500,  stride:-1};
    rd_addrs = '{0, 1, 5, 128, 255};

    ch = 2'd0; ramp_val = 12'd0; bg_val = 12'd3000; ramp_on = 1'b0; ramp_down = 1'b0;
    apply();
    sel = 2'd0; trig_level = 12'd0; trig_slope = 1'b1; decim = 8'd0;
    arm = 1'b0; abort = 1'b0; rd_addr = 8'd0;

    // Asynchronous reset at start
    #1 reset = 1'b0;
    #2;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_rd_data", rd_data, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    step();
    check("idle_busy", busy, 0);

    // Table-driven capture scenarios
    for (int r = 0; r < 5; r++) begin
      v = vecs[r];
      ch = v.sel; ramp_val = v.start; ramp_down = v.down; ramp_on = 1'b1;
      apply();
      sel = v.sel; trig_level = v.level; trig_slope = v.slope; decim = v.decim;
      arm = 1'b1;
      step();
      arm = 1'b0;
      sel = v.sel ^ 2'd1; trig_level = 12'd0; trig_slope = ~v.slope; decim = 8'd0;
      check($sformatf("v%0d_busy_after_arm", r), busy, 1);
      check($sformatf("v%0d_done_cleared", r), done, 0);
      done_at = -1;
      for (int j = 1; j <= v.done_edge + 20 && done_at < 0; j++) begin
        arm = (j == v.arm_pulse);
        step();
        arm = 1'b0;
        if (done === 1'b1) done_at = j;
      end
      check($sformatf("v%0d_done_edge", r), done_at, v.done_edge);
      check($sformatf("v%0d_busy_at_done", r), busy, 0);
      for (int a = 0; a < 5; a++) begin
        rd_addr = 8'(rd_addrs[a]);
        step();
        e = 12'(v.mem0 + v.stride * rd_addrs[a]);
        check($sformatf("v%0d_mem%0d", r, rd_addrs[a]), rd_data, e);
      end
    end

    // Same-cycle arm and abort from DONE
    arm = 1'b1; abort = 1'b1;
    step();
    arm = 1'b0; abort = 1'b0;
    check("armabort_done_busy", busy, 0);
    check("armabort_done_done", done, 0);

    // Reset in the middle of a capture
    ch = 2'd3; ramp_val = 12'd0; ramp_down = 1'b0; ramp_on = 1'b1; apply();
    sel = 2'd3; trig_level = 12'd100; trig_slope = 1'b1; decim = 8'd0; rd_addr = 8'd0;
    arm = 1'b1;
    step();
    arm = 1'b0;
    repeat (150) step();
    check("midcap_busy", busy, 1);
    check("midcap_rd_data", rd_data, 100);
    #2 reset = 1'b0;
    #1;
    check("midcap_reset_busy", busy, 0);
    check("midcap_reset_done", done, 0);
    check("midcap_reset_rd_data", rd_data, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    trig_level = 12'd0;
    cnt = 0;
    for (int j = 0; j < 20; j++) begin
      step();
      if (busy === 1'b0 && done === 1'b0) cnt++;
    end
    check("post_reset_idle_cycles", cnt, 20);

    // Stuck trigger, then abort
    ramp_on = 1'b0; ch = 2'd0; ramp_val = 12'd500; bg_val = 12'd500; apply();
    sel = 2'd0; trig_level = 12'd1000; trig_slope = 1'b1; decim = 8'd0;
    arm = 1'b1;
    step();
    arm = 1'b0;
    cnt = 0;
    for (int j = 0; j < 10000; j++) begin
      step();
      if (busy === 1'b1 && done === 1'b0) cnt++;
    end
    check("stuck_wait_cycles", cnt, 10000);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);

    // Level already at threshold when armed: no trigger without a lower prev
    ramp_val = 12'd1000; bg_val = 12'd1000; apply();
    arm = 1'b1;
    step();
    arm = 1'b0;
    repeat (300) step();
    check("level_at_arm_done", done, 0);
    check("level_at_arm_busy", busy, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;

    // Same-cycle arm and abort from IDLE
    arm = 1'b1; abort = 1'b1;
    step();
    arm = 1'b0; abort = 1'b0;
    check("armabort_idle_busy", busy, 0);
    repeat (5) step();
    check("armabort_idle_busy_later", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
